// File: rtl/ahb_cmd_decoder_if.sv
// Request bus between the JTAG AHB command decoder and the AHB master stage.
// The decoder drives the queued transfer; the master stage returns ready.
interface ahb_cmd_decoder_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [1:0]        req_size;

    modport master (
        output req_valid,
        output req_write,
        output req_addr,
        output req_wdata,
        output req_size,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_write,
        input  req_addr,
        input  req_wdata,
        input  req_size,
        output req_ready
    );
endinterface

// File: rtl/ahb_cmd_decoder.sv
// Decodes JTAG AHB DR updates into SET_ADDR/WRITE/READ/NOP commands, tracks the
// current address with auto-increment, and queues transfers in a FWFT FIFO.
module ahb_cmd_decoder #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                    TCK,
    input  logic                    tlr_reset,
    input  logic [40:0]             parallel_out,
    input  logic                    winc,
    ahb_cmd_decoder_if.master       req,
    output logic [$clog2(DEPTH):0]  fifo_count,
    output logic                    overflow,
    output logic [ADDR_W-1:0]       cur_addr
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    typedef enum logic [1:0] {
        OP_NOP      = 2'b00,
        OP_SET_ADDR = 2'b01,
        OP_WRITE    = 2'b10,
        OP_READ     = 2'b11
    } opcode_t;

    // Size 11 has no AHB meaning here; it is folded onto a word transfer.
    function automatic logic [1:0] norm_size(input logic [1:0] sz);
        return (sz == 2'b11) ? 2'b10 : sz;
    endfunction

    function automatic logic [ADDR_W-1:0] addr_step(input logic [1:0] sz);
        return ADDR_W'(1) << sz;
    endfunction

    opcode_t     op;
    logic        ainc;
    logic [1:0]  size_n;
    logic [31:0] payload;
    logic        unused_bits;

    assign op          = opcode_t'(parallel_out[40:39]);
    assign ainc        = parallel_out[36];
    assign size_n      = norm_size(parallel_out[35:34]);
    assign payload     = parallel_out[31:0];
    assign unused_bits = ^{parallel_out[38:37], parallel_out[33:32]};

    logic          winc_q;
    logic          fire;
    logic          is_xfer;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          full;
    logic          empty;
    logic          do_pop;
    logic          do_push;
    logic          drop;

    assign fire    = winc & ~winc_q & ~tlr_reset;
    assign is_xfer = fire & ((op == OP_WRITE) | (op == OP_READ));
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[PW-1] != rd_ptr[PW-1]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = ~empty & req.req_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign do_push = is_xfer & (~full | do_pop);
    assign drop    = is_xfer & full & ~do_pop;

    assign fifo_count = wr_ptr - rd_ptr;

    always_ff @(posedge TCK) begin
        if (tlr_reset) begin
            winc_q   <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
            cur_addr <= '0;
        end else begin
            winc_q <= winc;
            if (do_pop)
                rd_ptr <= rd_ptr + PW'(1);
            if (do_push)
                wr_ptr <= wr_ptr + PW'(1);
            if (drop)
                overflow <= 1'b1;
            if (fire && op == OP_SET_ADDR)
                cur_addr <= payload[ADDR_W-1:0];
            else if (do_push && ainc)
                cur_addr <= cur_addr + addr_step(size_n);
        end
    end

    // Storage holds no reset: entries are only visible between valid pointers.
    logic              mem_write [DEPTH];
    logic [ADDR_W-1:0] mem_addr  [DEPTH];
    logic [DATA_W-1:0] mem_wdata [DEPTH];
    logic [1:0]        mem_size  [DEPTH];
    logic [AW-1:0]     wr_idx;
    logic [AW-1:0]     rd_idx;

    assign wr_idx = wr_ptr[AW-1:0];
    assign rd_idx = rd_ptr[AW-1:0];

    always_ff @(posedge TCK) begin
        if (do_push) begin
            mem_write[wr_idx] <= (op == OP_WRITE);
            mem_addr[wr_idx]  <= cur_addr;
            mem_wdata[wr_idx] <= (op == OP_WRITE) ? payload[DATA_W-1:0] : '0;
            mem_size[wr_idx]  <= size_n;
        end
    end

    assign req.req_valid = ~empty;
    assign req.req_write = ~empty & mem_write[rd_idx];
    assign req.req_addr  = empty ? '0 : mem_addr[rd_idx];
    assign req.req_wdata = empty ? '0 : mem_wdata[rd_idx];
    assign req.req_size  = empty ? 2'b00 : mem_size[rd_idx];
endmodule

// File: tb/tb_ahb_cmd_decoder.sv
// Bench for ahb_cmd_decoder: directed scenarios plus randomized traffic against
// a queue-based reference model of the command/FIFO behaviour.
module tb_ahb_cmd_decoder;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    localparam logic [1:0] NOP = 2'b00, SET = 2'b01, WR = 2'b10, RD = 2'b11;

    logic        TCK = 1'b0;
    logic        tlr_reset;
    logic        winc;
    logic [40:0] parallel_out;
    logic [2:0]  fifo_count;
    logic        overflow;
    logic [31:0] cur_addr;

    always #5 TCK = ~TCK;

    ahb_cmd_decoder_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    ahb_cmd_decoder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .TCK          (TCK),
        .tlr_reset    (tlr_reset),
        .parallel_out (parallel_out),
        .winc         (winc),
        .req          (bus.master),
        .fifo_count   (fifo_count),
        .overflow     (overflow),
        .cur_addr     (cur_addr)
    );

    typedef struct {
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
        logic [1:0]  s;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] m_cur;
    logic        m_ovf;
    logic        m_wq;
    int          vectors;
    int          miscompares;

    function automatic logic [40:0] cmd(input logic [1:0] op, input logic ainc,
                                        input logic [1:0] sz, input logic [31:0] pl,
                                        input logic [3:0] junk);
        return {op, junk[3:2], ainc, sz, junk[1:0], pl};
    endfunction

    // Drive one cycle of inputs, advance the reference model, then clock.
    task automatic step(input logic r, input logic w, input logic [40:0] word, input logic rdy);
        logic [1:0] op;
        logic [1:0] s;
        ent_t       e;
        tlr_reset        = r;
        winc             = w;
        parallel_out     = word;
        bus.req_ready    = rdy;
        if (r) begin
            mq.delete();
            m_cur = '0;
            m_ovf = 1'b0;
            m_wq  = 1'b0;
        end else begin
            if (mq.size() > 0 && rdy)
                void'(mq.pop_front());
            if (w && !m_wq) begin
                op = word[40:39];
                s  = (word[35:34] == 2'b11) ? 2'b10 : word[35:34];
                if (op == SET) begin
                    m_cur = word[31:0];
                end else if (op == WR || op == RD) begin
                    if (mq.size() < DEPTH) begin
                        e.w = (op == WR);
                        e.a = m_cur;
                        e.d = (op == WR) ? word[31:0] : 32'h0;
                        e.s = s;
                        mq.push_back(e);
                        if (word[36])
                            m_cur = m_cur + (32'd1 << s);
                    end else begin
                        m_ovf = 1'b1;
                    end
                end
            end
            m_wq = w;
        end
        @(posedge TCK);
        #1;
    endtask

    task automatic issue(input logic [40:0] word, input logic rdy);
        step(1'b0, 1'b1, word, rdy);
        step(1'b0, 1'b0, word, rdy);
    endtask

    task automatic test_reset();
        step(1'b1, 1'b0, '0, 1'b0);
        step(1'b1, 1'b0, '0, 1'b0);
        vectors++; if (bus.req_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", bus.req_valid); end
        vectors++; if (fifo_count !== 3'd0) begin miscompares++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
        vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL reset_overflow: got %b want 0", overflow); end
        vectors++; if (cur_addr !== 32'h0) begin miscompares++; $display("FAIL reset_cur_addr: got %h want 0", cur_addr); end
        vectors++; if ({bus.req_write, bus.req_addr, bus.req_wdata, bus.req_size} !== '0) begin
            miscompares++; $display("FAIL reset_req_fields: got %b/%h/%h/%b want all 0", bus.req_write, bus.req_addr, bus.req_wdata, bus.req_size);
        end
    endtask

    task automatic test_write_ainc();
        step(1'b1, 1'b0, '0, 1'b1);
        issue(cmd(SET, 1'b0, 2'b00, 32'h1000_0000, 4'h0), 1'b1);
        step(1'b0, 1'b1, cmd(WR, 1'b1, 2'b10, 32'hDEAD_BEEF, 4'h0), 1'b1);
        vectors++; if (bus.req_valid !== 1'b1) begin miscompares++; $display("FAIL wr_valid: got %b want 1", bus.req_valid); end
        vectors++; if (bus.req_write !== 1'b1) begin miscompares++; $display("FAIL wr_write: got %b want 1", bus.req_write); end
        vectors++; if (bus.req_addr !== 32'h1000_0000) begin miscompares++; $display("FAIL wr_addr: got %h want 10000000", bus.req_addr); end
        vectors++; if (bus.req_wdata !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL wr_wdata: got %h want deadbeef", bus.req_wdata); end
        vectors++; if (bus.req_size !== 2'b10) begin miscompares++; $display("FAIL wr_size: got %b want 10", bus.req_size); end
        vectors++; if (cur_addr !== 32'h1000_0004) begin miscompares++; $display("FAIL wr_cur_addr: got %h want 10000004", cur_addr); end
        step(1'b0, 1'b0, '0, 1'b1);
        vectors++; if (fifo_count !== 3'd0) begin miscompares++; $display("FAIL wr_drain_count: got %0d want 0", fifo_count); end
        vectors++; if (bus.req_wdata !== 32'h0) begin miscompares++; $display("FAIL wr_idle_wdata: got %h want 0", bus.req_wdata); end
    endtask

    task automatic test_addr_wrap();
        step(1'b1, 1'b0, '0, 1'b0);
        issue(cmd(SET, 1'b0, 2'b00, 32'hFFFF_FFFE, 4'h0), 1'b0);
        step(1'b0, 1'b1, cmd(RD, 1'b1, 2'b01, 32'h1234_5678, 4'hF), 1'b0);
        vectors++; if (bus.req_addr !== 32'hFFFF_FFFE) begin miscompares++; $display("FAIL wrap_addr: got %h want fffffffe", bus.req_addr); end
        vectors++; if (bus.req_write !== 1'b0) begin miscompares++; $display("FAIL wrap_write: got %b want 0", bus.req_write); end
        vectors++; if (bus.req_wdata !== 32'h0) begin miscompares++; $display("FAIL wrap_rd_wdata: got %h want 0", bus.req_wdata); end
        vectors++; if (bus.req_size !== 2'b01) begin miscompares++; $display("FAIL wrap_size: got %b want 01", bus.req_size); end
        vectors++; if (cur_addr !== 32'h0) begin miscompares++; $display("FAIL wrap_cur_addr: got %h want 0", cur_addr); end
        step(1'b0, 1'b0, '0, 1'b1);
    endtask

    task automatic test_overflow();
        step(1'b1, 1'b0, '0, 1'b0);
        for (int i = 0; i < 5; i++)
            issue(cmd(WR, 1'b1, (i == 1) ? 2'b11 : 2'b10, 32'h100 + i, 4'h0), 1'b0);
        vectors++; if (fifo_count !== 3'd4) begin miscompares++; $display("FAIL ovf_count: got %0d want 4", fifo_count); end
        vectors++; if (overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_flag: got %b want 1", overflow); end
        vectors++; if (cur_addr !== 32'h10) begin miscompares++; $display("FAIL ovf_cur_addr: got %h want 10", cur_addr); end
        for (int i = 0; i < 4; i++) begin
            vectors++; if (bus.req_wdata !== 32'h100 + i) begin miscompares++; $display("FAIL ovf_order_wdata[%0d]: got %h want %h", i, bus.req_wdata, 32'h100 + i); end
            vectors++; if (bus.req_addr !== 32'(4 * i)) begin miscompares++; $display("FAIL ovf_order_addr[%0d]: got %h want %h", i, bus.req_addr, 4 * i); end
            vectors++; if (bus.req_size !== 2'b10) begin miscompares++; $display("FAIL ovf_size[%0d]: got %b want 10", i, bus.req_size); end
            step(1'b0, 1'b0, '0, 1'b1);
        end
        vectors++; if (bus.req_valid !== 1'b0) begin miscompares++; $display("FAIL ovf_fifth_seen: got valid %b want 0", bus.req_valid); end
        vectors++; if (overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
    endtask

    task automatic test_full_push_pop();
        step(1'b1, 1'b0, '0, 1'b0);
        for (int i = 0; i < 4; i++)
            issue(cmd(WR, 1'b0, 2'b10, 32'h200 + i, 4'h0), 1'b0);
        step(1'b0, 1'b1, cmd(WR, 1'b0, 2'b10, 32'h204, 4'h0), 1'b1);
        vectors++; if (fifo_count !== 3'd4) begin miscompares++; $display("FAIL pp_count: got %0d want 4", fifo_count); end
        vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL pp_overflow: got %b want 0", overflow); end
        step(1'b0, 1'b0, '0, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            vectors++; if (bus.req_wdata !== 32'h200 + i) begin miscompares++; $display("FAIL pp_order[%0d]: got %h want %h", i, bus.req_wdata, 32'h200 + i); end
            step(1'b0, 1'b0, '0, 1'b1);
        end
        vectors++; if (fifo_count !== 3'd0) begin miscompares++; $display("FAIL pp_drain_count: got %0d want 0", fifo_count); end
    endtask

    task automatic test_winc_held();
        step(1'b1, 1'b0, '0, 1'b0);
        for (int i = 0; i < 3; i++)
            step(1'b0, 1'b1, cmd(WR, 1'b1, 2'b10, 32'h55, 4'h0), 1'b0);
        step(1'b0, 1'b0, '0, 1'b0);
        vectors++; if (fifo_count !== 3'd1) begin miscompares++; $display("FAIL held_count: got %0d want 1", fifo_count); end
        vectors++; if (cur_addr !== 32'h4) begin miscompares++; $display("FAIL held_cur_addr: got %h want 4", cur_addr); end
        vectors++; if (bus.req_wdata !== 32'h55) begin miscompares++; $display("FAIL held_wdata: got %h want 55", bus.req_wdata); end
    endtask

    task automatic test_reset_mid();
        step(1'b1, 1'b0, '0, 1'b0);
        for (int i = 0; i < 3; i++)
            issue(cmd(WR, 1'b1, 2'b10, 32'h300 + i, 4'h0), 1'b0);
        vectors++; if (fifo_count !== 3'd3) begin miscompares++; $display("FAIL rmid_pre_count: got %0d want 3", fifo_count); end
        step(1'b1, 1'b1, cmd(WR, 1'b1, 2'b10, 32'h3FF, 4'h0), 1'b1);
        vectors++; if (bus.req_valid !== 1'b0) begin miscompares++; $display("FAIL rmid_valid: got %b want 0", bus.req_valid); end
        vectors++; if (fifo_count !== 3'd0) begin miscompares++; $display("FAIL rmid_count: got %0d want 0", fifo_count); end
        vectors++; if (cur_addr !== 32'h0) begin miscompares++; $display("FAIL rmid_cur_addr: got %h want 0", cur_addr); end
        vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL rmid_overflow: got %b want 0", overflow); end
    endtask

    task automatic test_random();
        logic [1:0]  op;
        logic [31:0] pl;
        ent_t        e;
        step(1'b1, 1'b0, '0, 1'b0);
        for (int c = 0; c < 1500; c++) begin
            op = 2'($urandom_range(0, 3));
            pl = $urandom;
            if (op == SET && $urandom_range(0, 2) == 0)
                pl = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 1) == 1),
                 cmd(op, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), pl, 4'($urandom_range(0, 15))),
                 ($urandom_range(0, 2) == 0));
            if (mq.size() > 0) e = mq[0];
            else e = '{w: 1'b0, a: 32'h0, d: 32'h0, s: 2'b00};
            vectors++; if (bus.req_valid !== (mq.size() > 0)) begin miscompares++; $display("FAIL rnd_valid@%0d: got %b want %b", c, bus.req_valid, mq.size() > 0); end
            vectors++; if (fifo_count !== 3'(mq.size())) begin miscompares++; $display("FAIL rnd_count@%0d: got %0d want %0d", c, fifo_count, mq.size()); end
            vectors++; if (overflow !== m_ovf) begin miscompares++; $display("FAIL rnd_overflow@%0d: got %b want %b", c, overflow, m_ovf); end
            vectors++; if (cur_addr !== m_cur) begin miscompares++; $display("FAIL rnd_cur_addr@%0d: got %h want %h", c, cur_addr, m_cur); end
            vectors++; if (bus.req_write !== e.w) begin miscompares++; $display("FAIL rnd_write@%0d: got %b want %b", c, bus.req_write, e.w); end
            vectors++; if (bus.req_addr !== e.a) begin miscompares++; $display("FAIL rnd_addr@%0d: got %h want %h", c, bus.req_addr, e.a); end
            vectors++; if (bus.req_wdata !== e.d) begin miscompares++; $display("FAIL rnd_wdata@%0d: got %h want %h", c, bus.req_wdata, e.d); end
            vectors++; if (bus.req_size !== e.s) begin miscompares++; $display("FAIL rnd_size@%0d: got %b want %b", c, bus.req_size, e.s); end
        end
    endtask

    initial begin
        vectors       = 0;
        miscompares   = 0;
        m_cur         = '0;
        m_ovf         = 1'b0;
        m_wq          = 1'b0;
        tlr_reset     = 1'b1;
        winc          = 1'b0;
        parallel_out  = '0;
        bus.req_ready = 1'b0;
        test_reset();
        test_write_ainc();
        test_addr_wrap();
        test_overflow();
        test_full_push_pop();
        test_winc_held();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/ahb_cmd_decoder.md
Name: ahb_cmd_decoder

Overview:
- Sits directly downstream of the JTAG AHB data register.
- On each DR update it captures the 41-bit word and decodes it as an AHB command. Commands are SET_ADDR, WRITE, READ or NOP.
- It keeps a current address register with optional auto-increment, and queues the decoded transfers in a small synchronous FIFO.
- The AHB master stage drains the FIFO over a valid/ready handshake. The block runs entirely in the TCK domain.

Parameters:
- DEPTH, 4, request FIFO entries; must be a power of 2, ≥2.
- ADDR_W, 32, address width; must be ≤ 32.
- DATA_W, 32, write data width; must be ≤ 32.

Ports:
- TCK  input  1  JTAG test clock; all state is updated on its rising edge.
- tlr_reset  input  1  synchronous, active-high reset, sampled on the TCK rising edge.
- parallel_out  input  41  captured DR word from the AHB data register.
- winc  input  1  DR-update strobe from the AHB data register.
- req_valid  output  1  FIFO head holds a valid request.
- req_ready  input  1  downstream accepts the head request this cycle.
- req_write  output  1  1 = AHB write, 0 = AHB read.
- req_addr  output  ADDR_W  transfer address.
- req_wdata  output  DATA_W  write data (0 for reads).
- req_size  output  2  HSIZE[1:0]: 00 byte, 01 half, 10 word.
- fifo_count  output  $clog2(DEPTH)+1  number of queued entries.
- overflow  output  1  sticky flag: a command was dropped because the FIFO was full.
- cur_addr  output  ADDR_W  current address register, for debug readback.

Behaviour:
- Command word layout:
  - [40:39] opcode: 00 NOP, 01 SET_ADDR, 10 WRITE, 11 READ.
  - [36] auto-increment enable (AINC).
  - [35:34] size.
  - [31:0] payload.
  - Bits [38:37] and [33:32] are ignored.
- Strobe detection:
  - A command fires on the rising edge of winc: winc=1 now and winc=0 in the previous cycle (winc_q).
  - A winc held high for several cycles produces exactly one command.
  - winc_q resets to 0.
- SET_ADDR: cur_addr <= payload[ADDR_W-1:0] on the next TCK edge. Nothing is queued.
- WRITE: enqueue {write=1, addr=cur_addr, wdata=payload[DATA_W-1:0], size}.
- READ: enqueue {write=0, addr=cur_addr, wdata=0, size}.
- NOP: no effect.
- Auto-increment:
  - Applies to WRITE or READ with AINC=1 that is actually enqueued.
  - cur_addr <= cur_addr + (1 << size) in the same cycle as the enqueue.
  - Addition is modulo 2^ADDR_W, so it wraps at all-ones to 0.
  - size=11 is treated as 10 (word) in both the FIFO entry and the increment.
- Latency: a command fires in cycle N (the winc rising edge) and appears at the FIFO head with req_valid=1 in cycle N+1, if the FIFO was empty.
- FIFO behaviour:
  - First-word-fall-through: the head fields are stable while req_valid=1 and req_ready=0.
  - Pop occurs on req_valid & req_ready.
  - Simultaneous push and pop is allowed and leaves the count unchanged, including when full. The pop frees the slot for the push in the same cycle.
- Full condition:
  - If a push is attempted while full with no pop in the same cycle, the command is dropped.
  - overflow <= 1, and cur_addr is not incremented.
- Empty condition: req_valid=0. req_ready is ignored; no pop, and the count does not go below 0.
- Pointer wrap: read/write pointers are $clog2(DEPTH)+1 bits. Full/empty are decided on the MSB compare.
- overflow is cleared only by tlr_reset.
- Reset values when tlr_reset=1 on an edge:
  - req_valid=0, fifo_count=0, overflow=0, cur_addr=0, winc_q=0.
  - req_write=0, req_addr=0, req_wdata=0, req_size=0.
  - Pointers are set to 0.
  - Reset has priority over a simultaneous winc edge or pop. Queued entries are discarded mid-operation.
- While req_valid=0, all req_* data outputs hold 0.

Test Plan:
- Reset, then SET_ADDR 0x1000_0000, then WRITE data 0xDEADBEEF with size=10, AINC=1, req_ready=1 → one cycle later: req_valid=1, req_write=1, req_addr=0x10000000, req_wdata=0xDEADBEEF. After it: cur_addr=0x10000004, fifo_count returns to 0.
- SET_ADDR 0xFFFFFFFE, then READ with size=01, AINC=1 → req_addr=0xFFFFFFFE, req_write=0. cur_addr wraps to 0x00000000.
- Hold req_ready=0 and issue 5 WRITEs with DEPTH=4 → fifo_count=4 and overflow=1. The 5th payload is never output. With AINC=1 from 0x0, word size, cur_addr=0x10 (not 0x14).
- FIFO full, with req_ready=1 in the same cycle as a winc edge → count stays 4, overflow stays 0. Outputs arrive in order.
- Hold winc high for 3 cycles carrying a WRITE → exactly one entry is queued.
- With 3 entries queued, assert tlr_reset for one cycle together with a winc edge → next cycle: req_valid=0, fifo_count=0, cur_addr=0, overflow=0.
